// File: rtl/raw_pixel_unpacker.sv
// raw_pixel_unpacker: CSI-2 RAW8/RAW10 payload bytes to 10-bit pixels with X/Y.
// Define RAW_PIXEL_UNPACKER_RAW10_EN to enable RAW10 (0x2B) decoding.
module raw_pixel_unpacker #(
  parameter int BUFFER_BYTES = 12
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [3:0][7:0] image_data,
  input  logic [2:0]      image_data_bytes,
  input  logic [5:0]      image_data_type,
  input  logic            image_data_enable,
  input  logic            frame_start,
  input  logic            line_start,
  output logic [9:0]      pixel,
  output logic            pixel_valid,
  input  logic            pixel_ready,
  output logic [15:0]     pixel_x,
  output logic [15:0]     pixel_y,
  output logic            overflow,
  output logic [15:0]     dropped_words
);
  localparam int BB = BUFFER_BYTES;
  localparam logic [5:0] DT_RAW8 = 6'h2A;
  localparam logic [5:0] DT_RAW10 = 6'h2B;
  localparam logic [5:0] PUSH_MAX = 6'(BB - 4);
`ifdef RAW_PIXEL_UNPACKER_RAW10_EN
  localparam bit HAS_RAW10 = 1'b1;
`else
  localparam bit HAS_RAW10 = 1'b0;
`endif

  logic [7:0]  buf_q [BB];
  logic [5:0]  cnt_q;
  logic        mode_q;
  logic [1:0]  grp_q;
  logic [9:0]  pix_q;
  logic        pv_q;
  logic [15:0] px_q, py_q;
  logic [15:0] col_q, row_q;
  logic        first_q;
  logic        ovf_q;
  logic [15:0] drop_q;

  logic        is8, is10, sup;
  logic        flush, push, load, mode_n;
  logic [5:0]  occ, tot, pop, cnt_d;
  logic [1:0]  grp_s, grp_d;
  logic [7:0]  cmb [BB+5];
  logic [7:0]  buf_d [BB];
  logic [7:0]  pb;
  logic [1:0]  lo;
  logic [9:0]  pix_d;
  logic [15:0] col_n, row_n;
  logic        first_n;

  always_comb begin
    is8 = image_data_type == DT_RAW8;
    is10 = HAS_RAW10 && image_data_type == DT_RAW10;
    sup = is8 || is10;
    // type change or an incomplete RAW10 residue at line start empties the buffer
    flush = (image_data_enable && sup && is10 != mode_q) ||
            (line_start && mode_q && grp_q == 2'd0 && cnt_q < 6'd5);
    occ = flush ? 6'd0 : cnt_q;
    push = image_data_enable && sup && occ <= PUSH_MAX;
    tot = occ + (push ? {3'd0, image_data_bytes} : 6'd0);
    mode_n = push ? is10 : mode_q;
    grp_s = flush ? 2'd0 : grp_q;

    // buffered bytes followed by this cycle's word
    for (int i = 0; i < BB; i++) cmb[i] = buf_q[i];
    for (int i = BB; i < BB + 5; i++) cmb[i] = 8'd0;
    for (int i = 0; i < BB; i++)
      for (int j = 0; j < 4; j++)
        if (push && j < int'(image_data_bytes) && i == int'(occ) + j)
          cmb[i] = image_data[j];

    unique case (grp_s)
      2'd0: begin pb = cmb[0]; lo = cmb[4][1:0]; end
      2'd1: begin pb = cmb[1]; lo = cmb[4][3:2]; end
      2'd2: begin pb = cmb[2]; lo = cmb[4][5:4]; end
      2'd3: begin pb = cmb[3]; lo = cmb[4][7:6]; end
    endcase
    pix_d = mode_n ? {pb, lo} : {cmb[0], 2'b00};

    load = (mode_n ? tot >= 6'd5 : tot != 6'd0) && (!pv_q || pixel_ready);
    pop = !load ? 6'd0 : !mode_n ? 6'd1 : grp_s == 2'd3 ? 6'd5 : 6'd0;
    grp_d = (load && mode_n) ? grp_s + 2'd1 : grp_s;
    cnt_d = tot - pop;
    for (int i = 0; i < BB; i++)
      buf_d[i] = pop == 6'd1 ? cmb[i+1] : pop == 6'd5 ? cmb[i+5] : cmb[i];

    first_n = first_q;
    row_n = row_q;
    col_n = col_q;
    if (frame_start) begin
      row_n = 16'd0;
      first_n = 1'b1;
    end
    if (line_start) begin
      col_n = 16'd0;
      if (first_n) first_n = 1'b0;
      else row_n = row_n + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BB; i++) buf_q[i] <= 8'd0;
      cnt_q <= 6'd0;
      mode_q <= 1'b0;
      grp_q <= 2'd0;
      pix_q <= 10'd0;
      pv_q <= 1'b0;
      px_q <= 16'd0;
      py_q <= 16'd0;
      col_q <= 16'd0;
      row_q <= 16'd0;
      first_q <= 1'b1;
      ovf_q <= 1'b0;
      drop_q <= 16'd0;
    end else begin
      for (int i = 0; i < BB; i++) buf_q[i] <= buf_d[i];
      cnt_q <= cnt_d;
      mode_q <= mode_n;
      grp_q <= grp_d;
      first_q <= first_n;
      row_q <= row_n;
      col_q <= load ? col_n + 16'd1 : col_n;
      pv_q <= load || (pv_q && !pixel_ready);
      if (load) begin
        pix_q <= pix_d;
        px_q <= col_n;
        py_q <= row_n;
      end
      if (image_data_enable && sup && !push) ovf_q <= 1'b1;
      if (image_data_enable && !sup && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
    end
  end

  assign pixel = pix_q;
  assign pixel_valid = pv_q;
  assign pixel_x = px_q;
  assign pixel_y = py_q;
  assign overflow = ovf_q;
  assign dropped_words = drop_q;
endmodule

// File: tb/tb_raw_pixel_unpacker.sv
// tb_raw_pixel_unpacker: directed and randomized checks of raw_pixel_unpacker
// against a byte-queue reference model.
module tb_raw_pixel_unpacker;
  typedef struct packed {
    logic [9:0]  p;
    logic [15:0] x;
    logic [15:0] y;
  } pix_t;

  logic            clock = 1'b0;
  logic            reset;
  logic [3:0][7:0] image_data;
  logic [2:0]      image_data_bytes;
  logic [5:0]      image_data_type;
  logic            image_data_enable;
  logic            frame_start;
  logic            line_start;
  logic [9:0]      pixel;
  logic            pixel_valid;
  logic            pixel_ready;
  logic [15:0]     pixel_x;
  logic [15:0]     pixel_y;
  logic            overflow;
  logic [15:0]     dropped_words;

  raw_pixel_unpacker #(.BUFFER_BYTES(12)) dut (
    .clock(clock),
    .reset(reset),
    .image_data(image_data),
    .image_data_bytes(image_data_bytes),
    .image_data_type(image_data_type),
    .image_data_enable(image_data_enable),
    .frame_start(frame_start),
    .line_start(line_start),
    .pixel(pixel),
    .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready),
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .overflow(overflow),
    .dropped_words(dropped_words)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  pix_t        exp_q[$];
  logic [7:0]  m_bytes[$];
  logic        m_mode;
  logic        m_first;
  logic        m_skip;
  logic [15:0] m_x, m_y, m_drop;
  logic        hold_v;
  logic [9:0]  hold_p;
  logic [15:0] hold_x, hold_y;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit m_is10(input logic [5:0] t);
`ifdef RAW_PIXEL_UNPACKER_RAW10_EN
    return t == 6'h2B;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_emit(input logic [9:0] v);
    pix_t e;
    e.p = v;
    e.x = m_x;
    e.y = m_y;
    exp_q.push_back(e);
    m_x = m_x + 16'd1;
  endtask

  task automatic m_clear();
    exp_q.delete();
    m_bytes.delete();
    m_mode = 1'b0;
    m_first = 1'b1;
    m_skip = 1'b0;
    m_x = 16'd0;
    m_y = 16'd0;
    m_drop = 16'd0;
    hold_v = 1'b0;
  endtask

  task automatic m_line(input logic fs, input logic ls);
    if (fs) begin
      m_y = 16'd0;
      m_first = 1'b1;
    end
    if (ls) begin
      m_x = 16'd0;
      if (m_first) m_first = 1'b0;
      else m_y = m_y + 16'd1;
      if (m_mode) m_bytes.delete();
    end
  endtask

  task automatic m_push(input logic [31:0] d, input int n, input logic [5:0] t);
    logic [7:0] b [5];
    if (t != 6'h2A && !m_is10(t)) begin
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      return;
    end
    if (m_skip) return;
    if (m_is10(t) != m_mode) m_bytes.delete();
    m_mode = m_is10(t);
    for (int k = 0; k < n; k++) m_bytes.push_back(d[8*k +: 8]);
    if (!m_mode) begin
      while (m_bytes.size() != 0) m_emit({m_bytes.pop_front(), 2'b00});
    end else begin
      while (m_bytes.size() >= 5) begin
        for (int k = 0; k < 5; k++) b[k] = m_bytes.pop_front();
        for (int k = 0; k < 4; k++)
          m_emit({b[k], 2'((b[4] >> (2 * k)) % 4)});
      end
    end
  endtask

  // one clock: score the pixel accepted at the coming edge, then drive inputs
  task automatic cyc(input logic en, input logic [31:0] d, input int n,
                     input logic [5:0] t, input logic fs, input logic ls,
                     input logic rdy);
    pix_t e;
    if (hold_v) begin
      check("hold_valid", 32'(pixel_valid), 1);
      check("hold_pix", 32'(pixel), 32'(hold_p));
      check("hold_x", 32'(pixel_x), 32'(hold_x));
      check("hold_y", 32'(pixel_y), 32'(hold_y));
    end
    if (pixel_valid && rdy) begin
      check("pix_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pix", 32'(pixel), 32'(e.p));
        check("pix_x", 32'(pixel_x), 32'(e.x));
        check("pix_y", 32'(pixel_y), 32'(e.y));
      end
    end
    hold_v = pixel_valid && !rdy;
    hold_p = pixel;
    hold_x = pixel_x;
    hold_y = pixel_y;
    pixel_ready = rdy;
    frame_start = fs;
    line_start = ls;
    image_data_enable = en;
    image_data = d;
    image_data_bytes = 3'(n);
    image_data_type = t;
    m_line(fs, ls);
    if (en) m_push(d, n, t);
    @(negedge clock);
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 32'd0, 0, 6'd0, 1'b0, 1'b0, rdy);
  endtask

  task automatic word(input logic [31:0] d, input int n, input logic [5:0] t,
                      input logic rdy);
    cyc(1'b1, d, n, t, 1'b0, 1'b0, rdy);
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      idle($urandom_range(0, 3) != 0);
      c++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    image_data_enable = 1'b0;
    frame_start = 1'b0;
    line_start = 1'b0;
    pixel_ready = 1'b0;
    image_data = '0;
    image_data_bytes = 3'd0;
    image_data_type = 6'd0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_clear();
  endtask

  task automatic check_reset_state();
    check("rst_pixel", 32'(pixel), 0);
    check("rst_valid", 32'(pixel_valid), 0);
    check("rst_x", 32'(pixel_x), 0);
    check("rst_y", 32'(pixel_y), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_drop", 32'(dropped_words), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check_reset_state();

    // RAW8 basic with one-cycle latency
    cyc(1'b0, 32'd0, 0, 6'd0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 0, 6'd0, 1'b0, 1'b1, 1'b1);
    word(32'h40302010, 4, 6'h2A, 1'b1);
    check("lat_raw8", 32'(pixel_valid), 1);
    word(32'h00006050, 2, 6'h2A, 1'b1);
    drain(50);

    // backpressure holds the first pixel
    cyc(1'b0, 32'd0, 0, 6'd0, 1'b0, 1'b1, 1'b1);
    word(32'h40302010, 4, 6'h2A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_pix", 32'(pixel), 32'h040);
      check("bp_x", 32'(pixel_x), 0);
      idle(1'b0);
    end
    drain(50);

    // overflow: fourth word lost while stalled
    cyc(1'b0, 32'd0, 0, 6'd0, 1'b0, 1'b1, 1'b1);
    word(32'h04030201, 4, 6'h2A, 1'b0);
    word(32'h08070605, 4, 6'h2A, 1'b0);
    word(32'h0C0B0A09, 4, 6'h2A, 1'b0);
    check("ovf_early", 32'(overflow), 0);
    m_skip = 1'b1;
    word(32'h100F0E0D, 4, 6'h2A, 1'b0);
    m_skip = 1'b0;
    check("ovf_set", 32'(overflow), 1);
    drain(100);

    // reset mid-operation discards buffered bytes
    word(32'h44332211, 4, 6'h2A, 1'b0);
    do_reset();
    check_reset_state();
    cyc(1'b0, 32'd0, 0, 6'd0, 1'b1, 1'b1, 1'b1);
    word(32'h000000AB, 1, 6'h2A, 1'b1);
    drain(50);

    // RAW10 unpack (dropped when RAW10 is disabled)
    word(32'hDDCCBBAA, 4, 6'h2B, 1'b1);
    word(32'h000000E4, 1, 6'h2B, 1'b1);
    drain(50);

    // RAW10 residue discarded at line start
    word(32'hDDCCBBAA, 4, 6'h2B, 1'b1);
    word(32'h030201E4, 4, 6'h2B, 1'b1);
    drain(50);
    cyc(1'b0, 32'd0, 0, 6'd0, 1'b0, 1'b1, 1'b1);
    word(32'h40302010, 4, 6'h2B, 1'b1);
    word(32'h000000FF, 1, 6'h2B, 1'b1);
    drain(50);
    cyc(1'b0, 32'd0, 0, 6'd0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 0, 6'd0, 1'b0, 1'b1, 1'b1);
    word(32'h8899AABB, 4, 6'h2B, 1'b1);
    word(32'h0000001B, 1, 6'h2B, 1'b1);
    drain(50);

    // unsupported data type
    for (int i = 0; i < 3; i++) word($urandom, 4, 6'h24, 1'b1);
    idle(1'b1);
    check("unsup_valid", 32'(pixel_valid), 0);
    check("unsup_drop", 32'(dropped_words), 32'(m_drop));

    // randomized lines
    for (int l = 0; l < 40; l++) begin
      logic [5:0] t;
      int nw;
      int r;
      r = $urandom_range(0, 3);
      t = (r < 2) ? 6'h2A : (r == 2) ? 6'h2B : 6'h24;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          cyc(1'b0, 32'd0, 0, 6'd0, 1'b1, 1'b1, 1'b1);
        end else begin
          cyc(1'b0, 32'd0, 0, 6'd0, 1'b1, 1'b0, 1'b1);
          cyc(1'b0, 32'd0, 0, 6'd0, 1'b0, 1'b1, 1'b1);
        end
      end else begin
        cyc(1'b0, 32'd0, 0, 6'd0, 1'b0, 1'b1, $urandom_range(0, 1) != 0);
      end
      nw = $urandom_range(1, 6);
      for (int w = 0; w < nw; w++) begin
        drain(200);
        word($urandom, (w == nw - 1) ? $urandom_range(1, 4) : 4, t,
             $urandom_range(0, 3) != 0);
      end
      drain(200);
      check("line_drop", 32'(dropped_words), 32'(m_drop));
      check("line_ovf", 32'(overflow), 0);
    end

    for (int i = 0; i < 10; i++) idle(1'b1);
    check("end_valid", 32'(pixel_valid), 0);
    check("end_drop", 32'(dropped_words), 32'(m_drop));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/raw_pixel_unpacker.md
# raw_pixel_unpacker

Sits directly downstream of the CSI-2 packet receiver: consumes its 4-byte image data words and line/frame markers, buffers the bytes, and emits one 10-bit pixel per cycle with valid/ready flow control plus per-frame X/Y coordinates. It decodes RAW8 (data type 0x2A) and RAW10 (data type 0x2B) payloads. All other image data types are dropped and counted.

## Interface
Parameters:
- `BUFFER_BYTES`, 12, byte buffer depth. Legal values are 8 to 32, and the value must be at least 8.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `image_data` in 4x8: payload bytes. Index 0 is the earliest byte on the wire.
- `image_data_bytes` in 3: number of valid bytes in `image_data`, 1 to 4. Valid bytes occupy indices 0 to n-1. Only the last word of a packet can be partial.
- `image_data_type` in 6: data type of the current packet.
- `image_data_enable` in 1: a word is present this cycle. There is no backpressure to upstream.
- `frame_start` in 1: single-cycle pulse.
- `line_start` in 1: single-cycle pulse.
- `pixel` out 10: output pixel.
- `pixel_valid` out 1: `pixel` holds a pixel.
- `pixel_ready` in 1: the consumer accepts the pixel.
- `pixel_x` out 16: column of `pixel`.
- `pixel_y` out 16: row of `pixel`.
- `overflow` out 1: sticky. Set when a word arrives while free space is less than 4 bytes.
- `dropped_words` out 16: number of words with an unsupported type, saturating.

## Operation
- **Reset values:** `pixel`=0, `pixel_valid`=0, `pixel_x`=0, `pixel_y`=0, `overflow`=0, `dropped_words`=0, buffer empty, `first_line`=1.
- **Push:**
  - When `image_data_enable` is high and the type is supported, append `image_data_bytes` bytes in index order.
  - If free space is less than 4 at that cycle, discard the whole word and set `overflow`.
- **Unsupported type:** discard the word and increment `dropped_words`. The counter saturates at 0xFFFF.
- **RAW8:** each byte b produces one pixel, {b, 2'b00}. One byte is popped per emitted pixel.
- **RAW10:** a group is 5 bytes, B0 to B4.
  - Pixel k = {Bk, B4[2k+1:2k]}, for k = 0 to 3.
  - Emission starts only when at least 5 bytes are buffered.
  - The 4 pixels are emitted in order k=0..3. The 5 bytes are popped after k=3 is accepted.
  - Group state: `group_idx`, 0 to 3.
- **Output stage:**
  - The output register is loaded when it is empty, or when it is being accepted (`pixel_valid && pixel_ready`) and the next pixel is available.
  - Push and pop in the same cycle are both honoured. Free space is computed from the occupancy before that cycle's pop.
- **Coordinates:**
  - `pixel_x` increments by 1 on each accepted pixel. It wraps modulo 2^16.
  - `frame_start` sets `pixel_y`=0 and `first_line`=1.
  - On `line_start`:
    - `pixel_x` is cleared.
    - If `first_line` is 1, clear it. Otherwise increment `pixel_y`.
- **Line_start flush:**
  - Residual buffered bytes that do not form a complete pixel are discarded. For RAW10 that is fewer than 5 bytes with `group_idx`=0. For RAW8 no residue is possible.
  - A pixel already in the output register is kept. It carries its old coordinates, which were latched when it was loaded.
- **Simultaneous pulses:** `frame_start` and `line_start` in the same cycle mean y=0, and `first_line` is cleared.
- **Mid-group type change:** if a word with a different supported type arrives mid-group, the buffer is flushed first and the word is then pushed.
- **Reset mid-operation:** reset returns all state to reset values immediately. Buffered bytes are lost.

## Timing
- Word pushed in cycle N:
  - RAW8: the first pixel has `pixel_valid` high in cycle N+1.
  - RAW10: the group becomes complete in cycle M, and the first pixel is valid in M+1.
- Throughput is 1 pixel per cycle while `pixel_ready` stays high.
- Input words arrive at most once per cycle. Sustained RAW8 input at 4 bytes per cycle overruns the buffer, and this is reported through `overflow`. No stall exists.
- `pixel`, `pixel_x` and `pixel_y` are stable while `pixel_valid && !pixel_ready`.
- Coordinates are registered together with `pixel`.

## Configuration
- `RAW_PIXEL_UNPACKER_RAW10_EN`
  - Defined: RAW10 path as described above.
  - Undefined: the group logic is removed, 0x2B is treated as unsupported (dropped and counted), and only RAW8 is decoded.

## Test plan
- **RAW8 basic:**
  - Stimulus: `frame_start`, `line_start`, then words {0x10,0x20,0x30,0x40} and {0x50,0x60}, with n=2 on the second, `pixel_ready`=1.
  - Required: pixels 0x040, 0x080, 0x0C0, 0x100, 0x140, 0x180 at x=0..5, y=0. The first is valid one cycle after the push.
- **RAW10 unpack** (macro defined):
  - Stimulus: words {0xAA,0xBB,0xCC,0xDD} then {0xE4}.
  - Required: pixels 0x2A8, 0x2ED, 0x332, 0x377, and the buffer is empty afterwards.
- **Backpressure:**
  - Stimulus: RAW8 with `pixel_ready` low for 5 cycles after the first valid.
  - Required: `pixel` stays 0x040 with x=0 throughout, and no pixel is lost once ready returns.
- **Overflow:**
  - Stimulus: `pixel_ready`=0 and 4 consecutive RAW8 words with `BUFFER_BYTES`=12.
  - Required: the fourth word is discarded and `overflow`=1.
- **Line handling:**
  - Stimulus: RAW10 with 3 residual bytes, then `line_start`.
  - Required: the residue is dropped, the next pixel has x=0 and y=1, and a second `frame_start` gives y=0.
- **Unsupported and macro-off:**
  - Stimulus: type 0x24 words ×3.
  - Required: `dropped_words`=3 and no `pixel_valid`.
  - With the macro undefined, type 0x2B words also increment `dropped_words`.
